// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Detects load-use hazards, inserts bubbles and counts stall bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_alusrc,
    input  logic             id_branch,
    input  logic [1:0]       id_aluop,
    input  logic             flush,
    output logic             hazard_stall,
    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_PC,
    output logic [XLEN-1:0]  ID_EX_Rs1Data,
    output logic [XLEN-1:0]  ID_EX_Rs2Data,
    output logic [XLEN-1:0]  ID_EX_Imm,
    output logic [4:0]       ID_EX_Rs,
    output logic [4:0]       ID_EX_Rt,
    output logic [4:0]       ID_EX_Rd,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_MemtoReg,
    output logic             ID_EX_ALUsrc,
    output logic             ID_EX_Branch,
    output logic [1:0]       ID_EX_ALUop,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic            branch;
        logic [1:0]      aluop;
    } id_ex_t;

    id_ex_t q;
    id_ex_t cap;
    logic   load_use;

    always_comb begin
        cap          = '0;
        cap.valid    = 1'b1;
        cap.pc       = id_pc;
        cap.rs1_data = id_rs1_data;
        cap.rs2_data = id_rs2_data;
        cap.imm      = id_imm;
        cap.rs       = id_rs;
        cap.rt       = id_rt;
        cap.rd       = id_rd;
        cap.regwrite = id_regwrite;
        cap.memread  = id_memread;
        cap.memwrite = id_memwrite;
        cap.memtoreg = id_memtoreg;
        cap.alusrc   = id_alusrc;
        cap.branch   = id_branch;
        cap.aluop    = id_aluop;
    end

    // rd==x0 never hazards: x0 is hardwired and the load result is dropped
    assign load_use = q.memread && (q.rd != 5'd0) && id_valid &&
                      ((q.rd == id_rs) ||
                       (id_uses_rt && (q.rd == id_rt)));

    assign hazard_stall = load_use && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (load_use) begin
            q <= '0;
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (id_valid) begin
            q <= cap;
        end else begin
            q <= '0;
        end
    end

    assign ID_EX_valid    = q.valid;
    assign ID_EX_PC       = q.pc;
    assign ID_EX_Rs1Data  = q.rs1_data;
    assign ID_EX_Rs2Data  = q.rs2_data;
    assign ID_EX_Imm      = q.imm;
    assign ID_EX_Rs       = q.rs;
    assign ID_EX_Rt       = q.rt;
    assign ID_EX_Rd       = q.rd;
    assign ID_EX_RegWrite = q.regwrite;
    assign ID_EX_MemRead  = q.memread;
    assign ID_EX_MemWrite = q.memwrite;
    assign ID_EX_MemtoReg = q.memtoreg;
    assign ID_EX_ALUsrc   = q.alusrc;
    assign ID_EX_Branch   = q.branch;
    assign ID_EX_ALUop    = q.aluop;

endmodule
